// File: rtl/sig_verifier_bank.sv
// Signature verifier bank: scans stored signatures one per clock, reports the match or the deepest
// failure reason, and locks out after repeated failures. Define SIGV_EXPIRY_EN to check expiry against cur_time.

module sig_verifier_bank #(
  parameter  int ENTRIES     = 4,
  parameter  int FIELD_W     = 8,
  parameter  int MAX_FAIL    = 3,
  parameter  int LOCK_CYCLES = 16,
  localparam int SIG_W       = 4 * FIELD_W,
  localparam int IDX_W       = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [IDX_W-1:0]   prog_idx,
  input  logic [SIG_W-1:0]   prog_sig,
  input  logic               prog_clr,
  output logic               prog_ready,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SIG_W-1:0]   req_sig,
  input  logic [FIELD_W-1:0] cur_time,
  output logic               rsp_valid,
  output logic               rsp_match,
  output logic [IDX_W-1:0]   rsp_idx,
  output logic [2:0]         rsp_code,
  output logic               locked
);

  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(ENTRIES - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, RESP, LOCK} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   scanIdx_q;
  logic [SIG_W-1:0]   reqSig_q;
  logic [2:0]         bestCode_q;
  logic [FAIL_W-1:0]  failCnt_q;
  logic [LOCK_W-1:0]  lockCnt_q;
  logic [SIG_W-1:0]   sigMem_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  logic               progAccept;
  logic [SIG_W-1:0]   entSig;
  logic               entValid;
  logic               expiryOk;
  logic [2:0]         cmpCode;
  logic [2:0]         deepCode;

  assign req_ready  = rst_n && (state_q == IDLE);
  assign prog_ready = rst_n && ((state_q == IDLE) || (state_q == LOCK));
  assign progAccept = prog_ready && (prog_idx <= LAST_IDX);

  // Clear beats write; out-of-range indices are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (progAccept) begin
      if (prog_clr) begin
        valid_q[prog_idx] <= 1'b0;
      end else if (prog_we) begin
        valid_q[prog_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (progAccept && prog_we && !prog_clr) begin
      sigMem_q[prog_idx] <= prog_sig;
    end
  end

`ifdef SIGV_EXPIRY_EN
  logic [FIELD_W-1:0] curTime_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curTime_q <= '0;
    end else if (req_valid && req_ready) begin
      curTime_q <= cur_time;
    end
  end

  assign expiryOk = (entSig[FIELD_W +: FIELD_W] == reqSig_q[FIELD_W +: FIELD_W]) &&
                    (reqSig_q[FIELD_W +: FIELD_W] >= curTime_q);
`else
  logic unusedCurTime;

  assign unusedCurTime = ^cur_time;
  assign expiryOk      = (entSig[FIELD_W +: FIELD_W] == reqSig_q[FIELD_W +: FIELD_W]);
`endif

  // Failure depth of the entry under scan: region, auth, sig_id, then expiry.
  always_comb begin
    entSig   = sigMem_q[scanIdx_q];
    entValid = valid_q[scanIdx_q];
    cmpCode  = 3'd0;
    if (!entValid || (entSig[3*FIELD_W +: FIELD_W] != reqSig_q[3*FIELD_W +: FIELD_W])) begin
      cmpCode = 3'd1;
    end else if (entSig[2*FIELD_W +: FIELD_W] != reqSig_q[2*FIELD_W +: FIELD_W]) begin
      cmpCode = 3'd2;
    end else if (entSig[0 +: FIELD_W] != reqSig_q[0 +: FIELD_W]) begin
      cmpCode = 3'd3;
    end else if (!expiryOk) begin
      cmpCode = 3'd4;
    end
    deepCode = (cmpCode > bestCode_q) ? cmpCode : bestCode_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scanIdx_q  <= '0;
      reqSig_q   <= '0;
      bestCode_q <= 3'd1;
      failCnt_q  <= '0;
      lockCnt_q  <= '0;
      rsp_valid  <= 1'b0;
      rsp_match  <= 1'b0;
      rsp_idx    <= '0;
      rsp_code   <= 3'd0;
      locked     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            reqSig_q   <= req_sig;
            scanIdx_q  <= '0;
            bestCode_q <= 3'd1;
            state_q    <= SEARCH;
          end
        end
        SEARCH: begin
          if (cmpCode == 3'd0) begin
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            rsp_match <= 1'b1;
            rsp_idx   <= scanIdx_q;
            rsp_code  <= 3'd0;
            failCnt_q <= '0;
          end else if (scanIdx_q == LAST_IDX) begin
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            rsp_match <= 1'b0;
            rsp_idx   <= '0;
            rsp_code  <= deepCode;
            failCnt_q <= (failCnt_q == FAIL_MAX) ? failCnt_q : failCnt_q + FAIL_W'(1);
          end else begin
            scanIdx_q  <= scanIdx_q + IDX_W'(1);
            bestCode_q <= deepCode;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          if (failCnt_q == FAIL_MAX) begin
            state_q   <= LOCK;
            locked    <= 1'b1;
            lockCnt_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        LOCK: begin
          if (lockCnt_q == LOCK_LAST) begin
            state_q   <= IDLE;
            locked    <= 1'b0;
            failCnt_q <= '0;
          end else begin
            lockCnt_q <= lockCnt_q + LOCK_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_verifier_bank.sv
// Self-checking bench for sig_verifier_bank: directed scenarios followed by randomized traffic,
// all checked against a loop-based reference model of the bank. Honours SIGV_EXPIRY_EN.

module tb_sig_verifier_bank;

  localparam int ENTRIES     = 4;
  localparam int FIELD_W     = 8;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [1:0]  prog_idx = '0;
  logic [31:0] prog_sig = '0;
  logic        prog_clr = 1'b0;
  logic        prog_ready;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_sig = '0;
  logic [7:0]  cur_time = '0;
  logic        rsp_valid;
  logic        rsp_match;
  logic [1:0]  rsp_idx;
  logic [2:0]  rsp_code;
  logic        locked;

  int total = 0;
  int bad   = 0;

  // Reference state: what the bank should hold, and the consecutive-failure count.
  bit          mValid [ENTRIES];
  logic [31:0] mSig   [ENTRIES];
  int          mFail  = 0;

  always #5 clk = ~clk;

  sig_verifier_bank #(
    .ENTRIES(ENTRIES), .FIELD_W(FIELD_W), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_we(prog_we), .prog_idx(prog_idx), .prog_sig(prog_sig), .prog_clr(prog_clr),
    .prog_ready(prog_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_sig(req_sig), .cur_time(cur_time),
    .rsp_valid(rsp_valid), .rsp_match(rsp_match), .rsp_idx(rsp_idx), .rsp_code(rsp_code),
    .locked(locked)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reason a single stored signature rejects the request (0 = accepted).
  function automatic int entryCode(input logic [31:0] e, input logic [31:0] r, input logic [7:0] t);
    if (e[31:24] != r[31:24]) return 1;
    if (e[23:16] != r[23:16]) return 2;
    if (e[7:0] != r[7:0]) return 3;
`ifdef SIGV_EXPIRY_EN
    if ((e[15:8] != r[15:8]) || (r[15:8] < t)) return 4;
`else
    if (e[15:8] != r[15:8]) return 4;
`endif
    return 0;
  endfunction

  function automatic void refModel(input logic [31:0] sig, input logic [7:0] t,
                                   output bit m, output int idx, output int code);
    int c;
    m = 0; idx = 0; code = 1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (mValid[i]) begin
        c = entryCode(mSig[i], sig, t);
        if (c == 0) begin
          m = 1; idx = i; code = 0;
          break;
        end
        if (c > code) code = c;
      end
    end
  endfunction

  task automatic progEntry(input int idx, input logic [31:0] sig, input bit we, input bit clr);
    int n = 0;
    @(negedge clk);
    while (prog_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checkOutput("prog_ready", {31'd0, prog_ready}, 32'd1);
    prog_we = we; prog_clr = clr; prog_idx = idx[1:0]; prog_sig = sig;
    @(posedge clk); #1;
    prog_we = 1'b0; prog_clr = 1'b0;
    if (clr) mValid[idx] = 0;
    else if (we) begin mValid[idx] = 1; mSig[idx] = sig; end
  endtask

  // One request from acceptance to response, plus lockout tracking when it is expected.
  task automatic applyStimulus(input logic [31:0] sig, input logic [7:0] t, input string tag,
                               input bit withProg = 0, input int pIdx = 0, input logic [31:0] pSig = '0);
    bit expM, expLock, sawReady, sawProgBusy;
    int expIdx, expCode, expLat, n;
    logic [31:0] lockSig;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checkOutput({tag, "/req_ready"}, {31'd0, req_ready}, 32'd1);
    if (withProg) begin
      prog_we = 1'b1; prog_idx = pIdx[1:0]; prog_sig = pSig;
      mValid[pIdx] = 1; mSig[pIdx] = pSig;
    end
    refModel(sig, t, expM, expIdx, expCode);
    expLat = expM ? expIdx + 1 : ENTRIES;
    req_valid = 1'b1; req_sig = sig; cur_time = t;
    @(posedge clk); #1;
    req_valid = 1'b0; prog_we = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (rsp_valid !== 1'b1 && n < 40);
    checkOutput({tag, "/rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    checkOutput({tag, "/latency"}, n, expLat);
    checkOutput({tag, "/rsp_match"}, {31'd0, rsp_match}, {31'd0, expM});
    checkOutput({tag, "/rsp_idx"}, {30'd0, rsp_idx}, expIdx);
    checkOutput({tag, "/rsp_code"}, {29'd0, rsp_code}, expCode);
    if (expM) mFail = 0;
    else if (mFail < MAX_FAIL) mFail++;
    expLock = (mFail == MAX_FAIL);
    @(posedge clk); #1;
    checkOutput({tag, "/pulse_end"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "/code_hold"}, {29'd0, rsp_code}, expCode);
    checkOutput({tag, "/locked"}, {31'd0, locked}, {31'd0, expLock});
    if (expLock) begin
      n = 0; sawReady = 0; sawProgBusy = 0; lockSig = $urandom;
      while (locked === 1'b1 && n < 100) begin
        if (req_ready !== 1'b0) sawReady = 1;
        if (prog_ready !== 1'b1) sawProgBusy = 1;
        if (n == 2) begin prog_we = 1'b1; prog_idx = 2'd3; prog_sig = lockSig; end
        if (n == 3) begin prog_we = 1'b0; mValid[3] = 1; mSig[3] = lockSig; end
        @(posedge clk); #1; n++;
      end
      prog_we = 1'b0;
      checkOutput({tag, "/lock_len"}, n, LOCK_CYCLES);
      checkOutput({tag, "/lock_req_ready"}, {31'd0, sawReady}, 32'd0);
      checkOutput({tag, "/lock_prog_ready"}, {31'd0, sawProgBusy}, 32'd0);
      checkOutput({tag, "/unlock_ready"}, {31'd0, req_ready}, 32'd1);
      mFail = 0;
    end
  endtask

  initial begin
    bit sawRsp;
    logic [31:0] s;
    for (int i = 0; i < ENTRIES; i++) begin mValid[i] = 0; mSig[i] = '0; end

    // Reset values while rst_n is held low.
    #2;
    checkOutput("rst/req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst/rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst/rsp_match", {31'd0, rsp_match}, 32'd0);
    checkOutput("rst/rsp_idx", {30'd0, rsp_idx}, 32'd0);
    checkOutput("rst/rsp_code", {29'd0, rsp_code}, 32'd0);
    checkOutput("rst/locked", {31'd0, locked}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst/req_ready", {31'd0, req_ready}, 32'd1);

    // Single entry, immediate match.
    progEntry(0, 32'h0A0110F3, 1, 0);
    applyStimulus(32'h0A0110F3, 8'h05, "match0");

    // Match found past a non-matching and an invalid entry.
    progEntry(0, 32'h0B000000, 1, 0);
    progEntry(2, 32'h0A0110F3, 1, 0);
    applyStimulus(32'h0A0110F3, 8'h05, "match2");

    // Three failure depths in a row trigger the lockout.
    progEntry(2, 32'h0, 0, 1);
    progEntry(0, 32'h0A0110F3, 1, 0);
    applyStimulus(32'h0B0110F3, 8'h05, "fail_region");
    applyStimulus(32'h0A0210F3, 8'h05, "fail_auth");
    applyStimulus(32'h0A0110AA, 8'h05, "fail_id");

    // Expiry mismatch.
    applyStimulus(32'h0A0111F3, 8'h05, "fail_expiry");
`ifdef SIGV_EXPIRY_EN
    applyStimulus(32'h0A0110F3, 8'h11, "expired");
    applyStimulus(32'h0A0110F3, 8'h10, "not_expired");
`endif

    // Write on the acceptance edge is visible to that request.
    applyStimulus(32'h77665544, 8'h05, "same_edge", 1, 1, 32'h77665544);

    // Clear wins over write on the same cycle.
    progEntry(1, 32'h77665544, 1, 1);
    applyStimulus(32'h77665544, 8'h05, "cleared");

    // Reset in the middle of a search: no response, bank emptied.
    @(negedge clk);
    req_valid = 1'b1; req_sig = 32'h0A0110F3; cur_time = 8'h05;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst/rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("mid_rst/req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("mid_rst/rsp_code", {29'd0, rsp_code}, 32'd0);
    sawRsp = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid !== 1'b0) sawRsp = 1; end
    checkOutput("mid_rst/no_pulse", {31'd0, sawRsp}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < ENTRIES; i++) mValid[i] = 0;
    mFail = 0;
    @(posedge clk); #1;
    checkOutput("mid_rst/ready_after", {31'd0, req_ready}, 32'd1);
    applyStimulus(32'h0A0110F3, 8'h05, "after_rst");

    // Randomized traffic drawn from a small field alphabet so matches and near-misses both occur.
    for (int i = 0; i < 60; i++) begin
      s = {($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0B,
           ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02,
           ($urandom_range(0, 1) == 0) ? 8'h10 : 8'h11,
           ($urandom_range(0, 1) == 0) ? 8'hF3 : 8'hAA};
      if ($urandom_range(0, 2) == 0)
        progEntry($urandom_range(0, ENTRIES - 1), s, 1, $urandom_range(0, 4) == 0);
      else
        applyStimulus(s, 8'($urandom_range(14, 18)), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
